// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants and payload type for the EX-stage control pipe.
//   ALU_*        ALU select encodings (ALU_NOP = 0 is the idle/bubble select)
//   NOP_IR_DEF   default instruction word driven when the stage is empty
//   ex_payload_t instruction word plus ALU select, default widths
package ctrl_pkg;

  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  localparam logic [15:0] NOP_IR_DEF = 16'h0000;

  typedef struct packed {
    logic [15:0] ir;
    logic [2:0]  alu_sel;
  } ex_payload_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: generic 2-entry (main + skid) pipeline register.
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_data     upstream payload, in_ready = skid empty
//   out_valid/out_data   main entry, out_ready from downstream
//   flush                drops main, skid and the incoming payload
// in_ready depends only on registered state, so there is no combinational
// path from out_ready back to upstream.
module pipe_skid_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  input  logic         flush
);

  logic         main_v_q, main_v_d;
  logic         skid_v_q, skid_v_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept;
  logic         xfer;

  assign in_ready  = !skid_v_q;
  assign out_valid = main_v_q;
  assign out_data  = main_q;
  assign accept    = in_valid && in_ready;
  assign xfer      = main_v_q && out_ready;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || xfer) begin
      // A full skid blocks accept, so skid and input never compete here.
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (accept) begin
        main_d   = in_data;
        main_v_d = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_d   = in_data;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

endmodule

// File: rtl/ctrl_ex_pipe.sv
// ctrl_ex_pipe: EX-stage control pipeline register with skid buffer.
//   clk, rst             clock, async active-low reset
//   i_ir_cache/i_valid   instruction from decode, o_ready = can accept
//   i_alu_sel_r          ALU select from decode
//   o_ir_mem/o_valid     instruction to MEM (NOP_IR when not valid)
//   i_ready              MEM accepts
//   o_alu_sel            ALU select (combinational or carried, by SEL_REG)
//   i_flush              kill held and incoming instructions
//   o_stall_cnt          saturating count of cycles held by downstream
module ctrl_ex_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned    IR_W    = 16,
  parameter int unsigned    SEL_W   = 3,
  parameter logic [IR_W-1:0] NOP_IR = IR_W'(NOP_IR_DEF),
  parameter bit             SEL_REG = 1'b0,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] i_alu_sel_r,
  input  logic [IR_W-1:0]  i_ir_cache,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [SEL_W-1:0] o_alu_sel,
  output logic [IR_W-1:0]  o_ir_mem,
  output logic             o_valid,
  input  logic             i_ready,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_stall_cnt
);

  logic [IR_W-1:0]  ir_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  if (SEL_REG) begin : g_sel_reg
    typedef struct packed {
      logic [IR_W-1:0]  ir;
      logic [SEL_W-1:0] alu_sel;
    } payload_t;

    payload_t pl_in, pl_out;

    assign pl_in.ir      = i_ir_cache;
    assign pl_in.alu_sel = i_alu_sel_r;

    pipe_skid_reg #(.W($bits(payload_t))) u_skid (
      .clk       (clk),
      .rst_n     (rst),
      .in_valid  (i_valid),
      .in_data   (pl_in),
      .in_ready  (o_ready),
      .out_valid (o_valid),
      .out_data  (pl_out),
      .out_ready (i_ready),
      .flush     (i_flush)
    );

    assign ir_q      = pl_out.ir;
    assign o_alu_sel = o_valid ? pl_out.alu_sel : {SEL_W{1'b0}};
  end else begin : g_sel_comb
    pipe_skid_reg #(.W(IR_W)) u_skid (
      .clk       (clk),
      .rst_n     (rst),
      .in_valid  (i_valid),
      .in_data   (i_ir_cache),
      .in_ready  (o_ready),
      .out_valid (o_valid),
      .out_data  (ir_q),
      .out_ready (i_ready),
      .flush     (i_flush)
    );

    assign o_alu_sel = (i_valid && !i_flush) ? i_alu_sel_r : {SEL_W{1'b0}};
  end

  // Stale payload stays in the register; mask it so MEM only sees NOPs.
  assign o_ir_mem = o_valid ? ir_q : NOP_IR;

  always_comb begin
    cnt_d = cnt_q;
    if (o_valid && !i_ready && !i_flush && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign o_stall_cnt = cnt_q;

endmodule
